// File: rtl/x25519_reduce.sv
// Final reduction of a 264-bit unreduced product to the canonical residue mod p = 2^255 - 19.
// Latency: en accepted at edge N, out/out_valid visible after edge N+3 (one result per 4 cycles max).
// Backpressure: none downstream; en is ignored while busy, and out holds until the next result.
//
// Ports:
//   clk        single clock, rising-edge
//   rst        asynchronous active-high reset
//   en         start strobe, honoured only when busy is low
//   a[263:0]   unreduced input, captured on the accepting edge
//   busy       high during FOLD1, FOLD2, FINAL
//   out_valid  one-cycle pulse when out carries a new result
//   out[255:0] reduced result in [0, p)
module x25519_reduce (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [263:0] a,
    output logic         busy,
    output logic         out_valid,
    output logic [255:0] out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FOLD1 = 2'd1;
    localparam logic [1:0] S_FOLD2 = 2'd2;
    localparam logic [1:0] S_FINAL = 2'd3;

    // p = 2^255 - 19 = 0x7fff...ffed
    localparam logic [255:0] P = {1'b0, {250{1'b1}}, 5'b01101};

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [263:0] x;
    logic [263:0] x_nxt;
    logic [255:0] out_nxt;
    logic         out_valid_nxt;

    // Fold datapath: 2^255 == 19 (mod p), so the 9 bits above bit 254 are
    // re-injected as 19*hi. 19*hi = 16*hi + 2*hi + hi, at most 9709 (14 bits).
    logic [8:0]   hi;
    logic [13:0]  hi19;
    logic [255:0] fold_sum;

    assign hi       = x[263:255];
    assign hi19     = {1'b0, hi, 4'b0000} + {4'b0000, hi, 1'b0} + {5'b00000, hi};
    assign fold_sum = {1'b0, x[254:0]} + {242'd0, hi19};

    // Final conditional subtract: after two folds x < 2^255 + 19 < 2p, so a
    // single subtraction of p suffices. The borrow out of the 257-bit
    // subtraction doubles as the x < p comparison.
    logic [256:0] sub_full;
    logic         below_p;

    assign sub_full = {1'b0, x[255:0]} - {1'b0, P};
    assign below_p  = sub_full[256];

    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt     = state;
        x_nxt         = x;
        out_nxt       = out;
        out_valid_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    x_nxt     = a;
                    state_nxt = S_FOLD1;
                end
            end
            S_FOLD1: begin
                x_nxt     = {8'd0, fold_sum};
                state_nxt = S_FOLD2;
            end
            S_FOLD2: begin
                x_nxt     = {8'd0, fold_sum};
                state_nxt = S_FINAL;
            end
            S_FINAL: begin
                // x[263:256] is zero here by construction of the second fold.
                out_nxt       = below_p ? x[255:0] : sub_full[255:0];
                out_valid_nxt = 1'b1;
                state_nxt     = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            x         <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            x         <= x_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_x25519_reduce.sv
// Self-checking bench for x25519_reduce against a plain "a mod p" reference.
// Latency: checks the 4-cycle en-to-valid timing on every operation.
// Backpressure: exercises en-while-busy rejection and full-rate back-to-back issue.
module tb_x25519_reduce;

    logic         clk;
    logic         rst;
    logic         en;
    logic [263:0] a;
    logic         busy;
    logic         out_valid;
    logic [255:0] out;

    int checks;
    int errors;
    int valid_cnt;
    longint cycle;

    x25519_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a         (a),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (out_valid) valid_cnt <= valid_cnt + 1;
    end

    // In FINAL the top 8 bits of the working register must already be zero.
    always @(negedge clk) begin
        if (!rst && dut.state == dut.S_FINAL) begin
            checks++;
            if (dut.x[263:256] !== 8'd0) begin
                errors++;
                $display("FAIL final_top_bits: x[263:256]=%0h required 0", dut.x[263:256]);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [255:0] ref_mod(input logic [263:0] v);
        logic [263:0] p264;
        logic [263:0] r;
        p264 = (264'd1 << 255) - 264'd19;
        r    = v % p264;
        return r[255:0];
    endfunction

    function automatic logic [263:0] rand264();
        logic [287:0] t;
        logic [263:0] v;
        logic [263:0] p264;
        p264 = (264'd1 << 255) - 264'd19;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
        v = t[263:0];
        case ($urandom_range(0, 4))
            0: v = p264 + 264'($urandom_range(0, 64)) - 264'd32;
            1: v = 264'($urandom);
            2: v = (264'd1 << 255) + 264'($urandom_range(0, 40)) - 264'd20;
            3: v = v | (264'h1ff << 255);
            default: ;
        endcase
        return v;
    endfunction

    // Drives one operation and waits (bounded) for out_valid; lat counts
    // rising edges from the accepting edge up to the valid cycle.
    task automatic issue_and_wait(input logic [263:0] val, output int lat,
                                  output logic [255:0] res, output bit busy_ok);
        en = 1'b1;
        a  = val;
        @(posedge clk);
        #1;
        en = 1'b0;
        a  = rand264();
        busy_ok = 1'b1;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            lat++;
            @(negedge clk);
        end
        if (!out_valid) lat = -1;
        if (busy !== 1'b0) busy_ok = 1'b0;
        res = out;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out !== 256'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: out=%0h out_valid=%b busy=%b required 0/0/0",
                         i, out, out_valid, busy);
            end
        end
    endtask

    task automatic test_boundary;
        logic [263:0] vals [6];
        logic [255:0] exps [6];
        logic [263:0] p264;
        int lat;
        logic [255:0] res;
        bit bok;
        p264 = (264'd1 << 255) - 264'd19;
        vals[0] = 264'd0;                  exps[0] = 256'd0;
        vals[1] = p264;                    exps[1] = 256'd0;
        vals[2] = p264 - 264'd1;           exps[2] = p264[255:0] - 256'd1;
        vals[3] = (264'd1 << 255) - 264'd1; exps[3] = 256'd18;
        vals[4] = (264'd1 << 255);         exps[4] = 256'd19;
        vals[5] = {264{1'b1}};             exps[5] = 256'd9727;
        for (int i = 0; i < 6; i++) begin
            issue_and_wait(vals[i], lat, res, bok);
            checks++;
            if (lat != 4 || !bok) begin
                errors++;
                $display("FAIL boundary_timing[%0d]: latency=%0d busy_ok=%b required 4/1", i, lat, bok);
            end
            checks++;
            if (res !== exps[i]) begin
                errors++;
                $display("FAIL boundary_value[%0d]: out=%0h required %0h", i, res, exps[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_busy_reject;
        int n0;
        int lat;
        n0 = valid_cnt;
        en = 1'b1;
        a  = (264'd1 << 255);
        @(posedge clk);
        #1;
        a = 264'd5;               // en stays high through the busy cycles
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != 4 || out !== 256'd19) begin
            errors++;
            $display("FAIL busy_reject_first: latency=%0d out=%0h required 4/13", lat, out);
        end
        // en is still high in the valid cycle, so the next edge accepts a=5.
        @(posedge clk);
        #1;
        en = 1'b0;
        a  = '0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != 4 || out !== 256'd5) begin
            errors++;
            $display("FAIL busy_reject_second: latency=%0d out=%0h required 4/5", lat, out);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (valid_cnt - n0 != 2) begin
            errors++;
            $display("FAIL busy_reject_pulses: count=%0d required 2", valid_cnt - n0);
        end
    endtask

    task automatic test_reset_midop;
        int n0;
        int lat;
        logic [255:0] res;
        bit bok;
        // Bring out to a nonzero value first so the reset clear is visible.
        issue_and_wait(264'd1234, lat, res, bok);
        @(negedge clk);
        en = 1'b1;
        a  = {264{1'b1}};
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 256'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%0h out_valid=%b busy=%b required 0/0/0", out, out_valid, busy);
        end
        @(negedge clk);
        n0 = valid_cnt;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (valid_cnt != n0 || out !== 256'd0) begin
            errors++;
            $display("FAIL reset_abort: pulses=%0d out=%0h required 0/0", valid_cnt - n0, out);
        end
        // en raised in the same cycle rst falls is taken on the next edge.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue_and_wait((264'd1 << 263) + 264'd77, lat, res, bok);
        checks++;
        if (lat != 4 || res !== ref_mod((264'd1 << 263) + 264'd77)) begin
            errors++;
            $display("FAIL reset_recover: latency=%0d out=%0h required 4/%0h",
                     lat, res, ref_mod((264'd1 << 263) + 264'd77));
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [263:0] v;
        int lat;
        logic [255:0] res;
        bit bok;
        for (int i = 0; i < 10000; i++) begin
            v = rand264();
            issue_and_wait(v, lat, res, bok);
            checks++;
            if (lat != 4 || !bok || res !== ref_mod(v)) begin
                errors++;
                $display("FAIL random[%0d]: a=%0h out=%0h latency=%0d required %0h latency 4",
                         i, v, res, lat, ref_mod(v));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [263:0] v;
        int lat;
        logic [255:0] res;
        bit bok;
        longint c0;
        int n0;
        c0 = cycle;
        n0 = valid_cnt;
        for (int i = 0; i < 32; i++) begin
            v = rand264();
            issue_and_wait(v, lat, res, bok);
            checks++;
            if (lat != 4 || res !== ref_mod(v)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: out=%0h latency=%0d required %0h latency 4",
                         i, res, lat, ref_mod(v));
            end
        end
        checks++;
        if (cycle - c0 != 128) begin
            errors++;
            $display("FAIL back_to_back_rate: cycles=%0d required 128", cycle - c0);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (valid_cnt - n0 != 32) begin
            errors++;
            $display("FAIL back_to_back_pulses: count=%0d required 32", valid_cnt - n0);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        valid_cnt = 0;
        cycle     = 0;
        rst       = 1'b1;
        en        = 1'b0;
        a         = '0;
        test_reset();
        test_boundary();
        test_busy_reject();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/x25519_reduce.md
# x25519_reduce

Final modular reduction stage for the X25519 datapath. It sits directly downstream of `X25519_MultPass`. It accepts the 264-bit unreduced accumulator that the multiplier produces, an integer below 2^264 packed little-endian. It returns the canonical residue modulo p = 2^255 − 19 as a 256-bit value in [0, p). The work is iterative: two fold cycles and one conditional-subtract cycle, for a fixed latency that the top-level sequencer can schedule around.

## Interface
Parameters:
- none; field width fixed at p = 2^255 − 19, input width fixed at 264 bits.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: start strobe; sampled only when `busy` = 0.
- `a` in 264: unreduced input, captured on the accepting edge.
- `busy` out 1: high while an operation is in flight (states FOLD1, FOLD2, FINAL).
- `out_valid` out 1: one-cycle pulse when `out` holds a new result.
- `out` out 256: reduced result; holds its value until the next result.

## Operation
- Internal state: 264-bit working register `x`; FSM with states IDLE, FOLD1, FOLD2, FINAL.
- fold(x) = zero-extend(x[254:0]) + 19 × x[263:255].
  - x[263:255] is 9 bits, max 511; 19 × 511 = 9709.
  - The sum fits in 256 bits and is zero-extended to 264 bits.
- IDLE:
  - en = 1: x ← a, go to FOLD1.
  - en = 0: stay in IDLE.
- FOLD1: x ← fold(x), go to FOLD2.
- FOLD2: x ← fold(x), go to FINAL.
- FINAL:
  - out ← (x ≥ p) ? x − p : x, using x[255:0].
  - out_valid ← 1, go to IDLE.
- Bound proof, so the fixed pass count is sufficient:
  - After FOLD1, x ≤ 2^255 − 1 + 9709.
  - After FOLD2, x < 2^255 + 19.
  - Hence after FINAL, out < p.
- In FINAL, x[263:256] is zero by construction; RTL may drop those bits, and a bench assertion checks they are zero.
- `en` while busy = 1 is ignored; `a` is not re-captured.
- `a` is don't-care except on the accepting edge.
- `out_valid` is registered, high for exactly one cycle per accepted operation.

## Timing
- Reset values: state IDLE, busy 0, out_valid 0, out 0, x 0.
- Latency:
  - `en` accepted at rising edge N.
  - `out_valid` and the new `out` are visible in the cycle after edge N+3, i.e. 4 cycles from the `en` cycle to the valid cycle.
- busy is high in the cycles after edges N, N+1 and N+2, and low in the out_valid cycle.
- Back-to-back: the FSM is in IDLE during the out_valid cycle, so `en` in that cycle is accepted.
  - Maximum throughput is one result per 4 cycles.
- Reset asserted mid-operation:
  - Immediate (asynchronous) return to reset values.
  - No out_valid is produced for the aborted operation.
- Reset deasserted with `en` = 1: accepted on the first rising edge after deassertion.
- Critical path: 255-bit add of lo + 19·hi in the fold; a 256-bit compare/subtract in FINAL. Single-cycle each at the multiplier clock.

## Test plan
- Reset then idle: out = 0, out_valid = 0, busy = 0 for 10 cycles with en = 0.
- Boundary values, each producing out_valid exactly 4 cycles after en:
  - a = 0 → out = 0
  - a = p → out = 0
  - a = p − 1 → out = p − 1
  - a = 2^255 − 1 → out = 18
  - a = 2^255 → out = 19
- Max input: a = 2^264 − 1 → out = 9727 (0x25FF), exercising both folds.
- Busy rejection:
  - en with a = 2^255, then en held high with a = 5 during the 3 busy cycles.
  - Result out = 19; one out_valid only.
  - The en held high during the out_valid cycle then starts a new operation with a = 5 → out = 5.
- Reset mid-op: en with a = 2^264 − 1, assert rst after 2 cycles → out stays 0, no out_valid; a new operation afterwards completes correctly.
- Randomized: 10,000 random 264-bit inputs at random gaps, checked against a reference a mod p; back-to-back issue at full rate (one per 4 cycles).
